// File: rtl/sram_2port_arb.sv
// Two-port single-bank synchronous memory with round-robin arbitration,
// byte-enable writes, pipelined read latency and optional zero-fill after reset.
module sram_2port_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16384,
  parameter int unsigned LATENCY    = 1,
  parameter bit          INIT_ZERO  = 1'b1,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p0_req,
  output logic                    p0_gnt,
  input  logic                    p0_we,
  input  logic [AW-1:0]           p0_addr,
  input  logic [DATA_WIDTH/8-1:0] p0_be,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  output logic                    p0_rvalid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_req,
  output logic                    p1_gnt,
  input  logic                    p1_we,
  input  logic [AW-1:0]           p1_addr,
  input  logic [DATA_WIDTH/8-1:0] p1_be,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic                    init_done
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t RST_STATE = INIT_ZERO ? S_INIT : S_RUN;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            last_q;
  logic            run;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_v, acc_p, acc_we, oor;
  logic [AW-1:0]         acc_addr;
  logic [NB-1:0]         acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata, acc_d;
  logic                  ent_v, ent_p;
  logic [DATA_WIDTH-1:0] ent_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end
  end

  assign run       = (state_q == S_RUN);
  assign init_done = run;

  // last_q = 1 means p1 was granted most recently, so p0 wins a conflict
  always_comb begin
    p0_gnt = run & p0_req & (~p1_req | last_q);
    p1_gnt = run & p1_req & (~p0_req | ~last_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_q <= 1'b1;
    else if (acc_v) last_q <= acc_p;
  end

  always_comb begin
    acc_v     = p0_gnt | p1_gnt;
    acc_p     = p1_gnt;
    acc_we    = acc_p ? p1_we    : p0_we;
    acc_addr  = acc_p ? p1_addr  : p0_addr;
    acc_be    = acc_p ? p1_be    : p0_be;
    acc_wdata = acc_p ? p1_wdata : p0_wdata;
  end

  if (2 ** AW == DEPTH) begin : g_pow2
    assign oor = 1'b0;
  end else begin : g_npow2
    assign oor = (acc_addr > LAST_ADDR);
  end

  always_comb begin
    acc_d = '0;
    if (acc_v && !acc_we && !oor) acc_d = mem[acc_addr];
  end

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[cnt_q] <= '0;
    end else if (acc_v && acc_we && !oor) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (acc_be[b]) mem[acc_addr][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // The per-port output registers form the last pipeline stage, so only
  // LATENCY-1 internal stages sit in front of them.
  if (LATENCY == 1) begin : g_direct
    assign ent_v = acc_v;
    assign ent_p = acc_p;
    assign ent_d = acc_d;
  end else begin : g_pipe
    logic [LATENCY-2:0]    pv, pp;
    logic [DATA_WIDTH-1:0] pd [LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        pp <= '0;
      end else begin
        pv[0] <= acc_v;
        pp[0] <= acc_p;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          pv[i] <= pv[i-1];
          pp[i] <= pp[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      pd[0] <= acc_d;
      for (int unsigned i = 1; i < LATENCY - 1; i++) pd[i] <= pd[i-1];
    end

    assign ent_v = pv[LATENCY-2];
    assign ent_p = pp[LATENCY-2];
    assign ent_d = pd[LATENCY-2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= ent_v & ~ent_p;
      p1_rvalid <= ent_v & ent_p;
      if (ent_v && !ent_p) p0_rdata <= ent_d;
      if (ent_v && ent_p)  p1_rdata <= ent_d;
    end
  end

endmodule

// File: tb/tb_sram_2port_arb.sv
// Directed self-checking bench: four instances (LATENCY 1..4, DEPTH 64) share
// stimulus; expected grants and response data are given per vector.
module tb_sram_2port_arb;

  localparam int NI = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [5:0]  p0_addr, p1_addr;
  logic [3:0]  p0_be, p1_be;
  logic [31:0] p0_wdata, p1_wdata;

  logic        p0_gnt_w [NI], p1_gnt_w [NI];
  logic        p0_rvalid_w [NI], p1_rvalid_w [NI];
  logic [31:0] p0_rdata_w [NI], p1_rdata_w [NI];
  logic        init_done_w [NI];

  logic        exp_g0, exp_g1, mon_en;
  logic [31:0] exp_d0, exp_d1;
  resp_t       eq [2*NI][$];
  logic [31:0] last_d [2*NI];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_2port_arb #(.DATA_WIDTH(32), .DEPTH(64), .LATENCY(g + 1), .INIT_ZERO(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_gnt(p0_gnt_w[g]), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_be(p0_be), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid_w[g]), .p0_rdata(p0_rdata_w[g]),
      .p1_req(p1_req), .p1_gnt(p1_gnt_w[g]), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_be(p1_be), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid_w[g]), .p1_rdata(p1_rdata_w[g]),
      .init_done(init_done_w[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response scoreboard: queue index = 2*instance + port.
  always @(negedge clk) begin
    logic        v;
    logic [31:0] d;
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        check_eq($sformatf("gnt0 L%0d", i + 1), 32'(p0_gnt_w[i]), 32'(exp_g0));
        check_eq($sformatf("gnt1 L%0d", i + 1), 32'(p1_gnt_w[i]), 32'(exp_g1));
      end
      for (int q = 0; q < 2*NI; q++) begin
        v = (q % 2 == 1) ? p1_rvalid_w[q/2] : p0_rvalid_w[q/2];
        d = (q % 2 == 1) ? p1_rdata_w[q/2]  : p0_rdata_w[q/2];
        if (eq[q].size() > 0 && eq[q][0].due == cyc) begin
          check_eq($sformatf("rvalid L%0d p%0d", q/2 + 1, q % 2), 32'(v), 32'd1);
          check_eq($sformatf("rdata L%0d p%0d", q/2 + 1, q % 2), d, eq[q][0].data);
          last_d[q] = eq[q][0].data;
          void'(eq[q].pop_front());
        end else begin
          check_eq($sformatf("rvalid idle L%0d p%0d", q/2 + 1, q % 2), 32'(v), 32'd0);
          check_eq($sformatf("rdata hold L%0d p%0d", q/2 + 1, q % 2), d, last_d[q]);
        end
      end
      for (int i = 0; i < NI; i++) begin
        if (exp_g0) eq[2*i].push_back('{cyc + i + 1, exp_d0});
        if (exp_g1) eq[2*i+1].push_back('{cyc + i + 1, exp_d1});
      end
    end
  end

  task automatic set_idle();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_be = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_be = '0; p1_wdata = '0;
    exp_g0 = 0; exp_g1 = 0; exp_d0 = '0; exp_d1 = '0;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [5:0] a0, input logic [3:0] b0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic [5:0] a1,
                       input logic [3:0] b1, input logic [31:0] d1, input logic g0, input logic g1,
                       input logic [31:0] e0, input logic [31:0] e1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_be = b0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_be = b1; p1_wdata = d1;
    exp_g0 = g0; exp_g1 = g1; exp_d0 = e0; exp_d1 = e1;
    @(posedge clk); #1;
  endtask

  task automatic rd0(input logic [5:0] a, input logic [31:0] e);
    drive(1, 0, a, 4'h0, '0, 0, 0, '0, 4'h0, '0, 1, 0, e, '0);
  endtask
  task automatic rd1(input logic [5:0] a, input logic [31:0] e);
    drive(0, 0, '0, 4'h0, '0, 1, 0, a, 4'h0, '0, 0, 1, '0, e);
  endtask
  task automatic wr0(input logic [5:0] a, input logic [3:0] b, input logic [31:0] d);
    drive(1, 1, a, b, d, 0, 0, '0, 4'h0, '0, 1, 0, '0, '0);
  endtask
  task automatic wr1(input logic [5:0] a, input logic [3:0] b, input logic [31:0] d);
    drive(0, 0, '0, 4'h0, '0, 1, 1, a, b, d, 0, 1, '0, '0);
  endtask
  task automatic idle(input int n);
    set_idle();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < NI; i++) begin
      check_eq("rst init_done", 32'(init_done_w[i]), 32'd0);
      check_eq("rst gnt0", 32'(p0_gnt_w[i]), 32'd0);
      check_eq("rst gnt1", 32'(p1_gnt_w[i]), 32'd0);
      check_eq("rst rvalid0", 32'(p0_rvalid_w[i]), 32'd0);
      check_eq("rst rvalid1", 32'(p1_rvalid_w[i]), 32'd0);
      check_eq("rst rdata0", p0_rdata_w[i], 32'd0);
      check_eq("rst rdata1", p1_rdata_w[i], 32'd0);
    end
  endtask

  task automatic check_drained();
    for (int q = 0; q < 2*NI; q++) check_eq("drained", 32'(eq[q].size()), 32'd0);
  endtask

  // Called just after a posedge with rst_n low; both ports request throughout INIT.
  task automatic run_init();
    set_idle();
    p0_req = 1; p1_req = 1; p1_addr = 6'd1;
    rst_n = 1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check_eq("init_done low", 32'(init_done_w[i]), 32'd0);
        check_eq("init gnt0", 32'(p0_gnt_w[i]), 32'd0);
        check_eq("init gnt1", 32'(p1_gnt_w[i]), 32'd0);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) check_eq("init_done high", 32'(init_done_w[i]), 32'd1);
    mon_en = 1;
  endtask

  task automatic arb6();
    for (int k = 0; k < 6; k++)
      drive(1, 0, 6'd0, 4'h0, '0, 1, 0, 6'd1, 4'h0, '0, (k % 2 == 0), (k % 2 == 1), '0, '0);
  endtask

  initial begin
    rst_n = 0;
    mon_en = 0;
    set_idle();
    for (int q = 0; q < 2*NI; q++) last_d[q] = '0;
    p0_req = 1; p1_req = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();

    // Zero-fill, then a conflict straight out of INIT: p0 first
    run_init();
    arb6();
    for (int a = 0; a < 64; a++) rd0(6'(a), 32'h0);

    // Byte merge and no-op write
    wr0(6'd5, 4'hF, 32'hAABBCCDD);
    wr0(6'd5, 4'b0101, 32'h11223344);
    rd0(6'd5, 32'hAA22CC44);
    wr0(6'd5, 4'h0, 32'hFFFFFFFF);
    rd0(6'd5, 32'hAA22CC44);

    // p0 granted last, so p1 wins this conflict
    for (int k = 0; k < 4; k++)
      drive(1, 0, 6'd5, 4'h0, '0, 1, 0, 6'd6, 4'h0, '0, (k % 2 == 1), (k % 2 == 0), 32'hAA22CC44, '0);

    // Read-after-write across ports
    wr0(6'd3, 4'hF, 32'hDEADBEEF);
    rd1(6'd3, 32'hDEADBEEF);

    // Back-to-back p1 traffic
    for (int a = 0; a < 8; a++) wr1(6'(a), 4'hF, 32'hC0DE0000 + 32'(a) * 32'h11);
    for (int a = 0; a < 8; a++) rd1(6'(a), 32'hC0DE0000 + 32'(a) * 32'h11);
    idle(6);
    check_drained();

    // Reset one cycle after a grant: only the LATENCY=1 response escapes
    rd1(6'd7, 32'hC0DE0077);
    set_idle();
    @(negedge clk); #1;
    mon_en = 0;
    rst_n = 0;
    for (int q = 0; q < 2*NI; q++) begin
      eq[q].delete();
      last_d[q] = '0;
    end
    p0_req = 1; p1_req = 1;
    #1;
    check_reset_outputs();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check_eq("flush rvalid0", 32'(p0_rvalid_w[i]), 32'd0);
        check_eq("flush rvalid1", 32'(p1_rvalid_w[i]), 32'd0);
      end
    end
    @(posedge clk); #1;
    run_init();
    arb6();
    rd1(6'd7, 32'h0);
    idle(6);
    check_drained();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
